flash_arbiter: RTL and testbench

//  Sequences the 16-bit flash handshake (ce/we/addr/data/ready) and shares it between two
//  32-bit word requesters: port 0 (boot loader / instruction fetch), port 1 (data/MMU).

---
 rtl/flash_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_flash_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// Two-port 32-bit word arbiter over a 16-bit ready/enable flash handshake.
// Optional ready-edge watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int FLASH_DW    = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [2*FLASH_DW-1:0] m0_wdata,
  output logic [2*FLASH_DW-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [2*FLASH_DW-1:0] m1_wdata,
  output logic [2*FLASH_DW-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic [ADDR_W:0]       flash_addr_o,
  output logic                  flash_ce_o,
  output logic                  flash_we_o,
  output logic [FLASH_DW-1:0]   flash_data_o,
  input  logic [FLASH_DW-1:0]   flash_data_i,
  input  logic                  flash_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int WORD_W = 2 * FLASH_DW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    REL_LO = 3'd2,
    REQ_HI = 3'd3,
    REL_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                prio_q, prio_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [WORD_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [WORD_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic [WORD_W-1:0]   done_word;
  logic                waiting;
  logic                timeout_hit;
  logic                timed_out;
  logic                half;

  assign waiting = (state_q == REQ_LO) || (state_q == REL_LO) ||
                   (state_q == REQ_HI) || (state_q == REL_HI);

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  assign timeout_hit = waiting && (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    timer_d = '0;
    err_d   = err_q;
    if (waiting && (state_d == state_q)) timer_d = timer_q + 1'b1;
    if (state_q == DONE) err_d = 1'b0;
    else if (state_d == DONE) err_d = timed_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Grant needs ready low so a stale ready level is never taken as completion.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    prio_d    = prio_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if ((m0_req || m1_req) && !flash_ready_i) begin
          port_d  = (m0_req && m1_req) ? prio_q : m1_req;
          prio_d  = ~port_d;
          we_d    = port_d ? m1_we    : m0_we;
          addr_d  = port_d ? m1_addr  : m0_addr;
          wdata_d = port_d ? m1_wdata : m0_wdata;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (flash_ready_i) begin
          if (!we_q) buf_d[FLASH_DW-1:0] = flash_data_i;
          state_d = REL_LO;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      REL_LO: begin
        if (!flash_ready_i) begin
          state_d = REQ_HI;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      REQ_HI: begin
        if (flash_ready_i) begin
          if (!we_q) buf_d[WORD_W-1:FLASH_DW] = flash_data_i;
          state_d = REL_HI;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      REL_HI: begin
        if (!flash_ready_i) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands on entry to DONE so it is already valid in the ack cycle.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    done_word  = timed_out ? '0 : buf_q;
    if ((state_d == DONE) && (state_q != DONE) && !we_q) begin
      if (port_q) m1_rdata_d = done_word;
      else        m0_rdata_d = done_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      prio_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      prio_q     <= prio_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign half         = (state_q == REQ_HI) || (state_q == REL_HI);
  assign flash_ce_o   = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign flash_we_o   = flash_ce_o && we_q;
  assign flash_addr_o = {addr_q, half};
  assign flash_data_o = half ? wdata_q[WORD_W-1:FLASH_DW] : wdata_q[FLASH_DW-1:0];
  assign busy_o       = (state_q != IDLE);
  assign m0_ack       = (state_q == DONE) && !port_q;
  assign m1_ack       = (state_q == DONE) && port_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a one-cycle registered-ready flash model.
// Default build only (FLASH_ARB_TIMEOUT_EN undefined).
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [21:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [22:0] flash_addr;
  logic        flash_ce, flash_we;
  logic [15:0] flash_dout, flash_din;
  logic        flash_ready;
  logic        busy, err;

  logic [15:0] mem [0:255];
  logic        ready_q = 1'b0;
  logic        force_ready = 1'b0;
  logic [15:0] rd_q = 16'h0;
  logic [22:0] wr_addr_log [0:7];
  logic [15:0] wr_data_log [0:7];
  int          wr_count = 0;
  int          m0_ack_cnt = 0;
  int          m1_ack_cnt = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  flash_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .flash_addr_o(flash_addr), .flash_ce_o(flash_ce), .flash_we_o(flash_we),
    .flash_data_o(flash_dout), .flash_data_i(flash_din),
    .flash_ready_i(flash_ready), .busy_o(busy), .err_o(err)
  );

  // Flash: ready follows ce one cycle later; the access happens on the rising ce edge.
  assign flash_ready = ready_q | force_ready;
  assign flash_din   = rd_q;

  always @(posedge clk) begin
    ready_q <= flash_ce;
    if (flash_ce && !ready_q) begin
      if (flash_we) begin
        mem[flash_addr[7:0]] <= flash_dout;
        if (wr_count < 8) begin
          wr_addr_log[wr_count] <= flash_addr;
          wr_data_log[wr_count] <= flash_dout;
        end
        wr_count <= wr_count + 1;
      end else begin
        rd_q <= mem[flash_addr[7:0]];
      end
    end
    if (m0_ack) m0_ack_cnt <= m0_ack_cnt + 1;
    if (m1_ack) m1_ack_cnt <= m1_ack_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_req(input int port, input logic we, input logic [21:0] addr,
                           input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Latency in cycles from the request cycle to the ack cycle; 40 means no ack seen.
  task automatic wait_ack(input int port, output int lat);
    lat = 0;
    @(negedge clk);
    while (!(port == 1 ? m1_ack : m0_ack) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (port == 1) m1_req = 1'b0;
    else           m0_req = 1'b0;
  endtask

  task automatic wait_both(output int lat0, output int lat1);
    lat0 = 40;
    lat1 = 40;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m0_ack && lat0 == 40) begin lat0 = n; m0_req = 1'b0; end
      if (m1_ack && lat1 == 40) begin lat1 = n; m1_req = 1'b0; end
      if (lat0 != 40 && lat1 != 40) break;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    int lat, lat0, lat1, acks_before;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h20] = 16'h1234;
    mem[8'h21] = 16'hABCD;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    do_reset();

    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ce", {31'd0, flash_ce}, 32'd0);
    checkOutput("rst_we", {31'd0, flash_we}, 32'd0);
    checkOutput("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_addr", {9'd0, flash_addr}, 32'd0);
    checkOutput("rst_data", {16'd0, flash_dout}, 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);

    // Single m0 read of word 0x10 -> halfwords 0x20/0x21
    @(posedge clk); #1;
    start_req(0, 1'b0, 22'h10, 32'h0);
    wait_ack(0, lat);
    checkOutput("m0_rd_latency", lat, 32'd9);
    checkOutput("m0_rd_data", m0_rdata, 32'hABCD1234);
    checkOutput("m0_rd_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    checkOutput("m0_ack_pulse", {31'd0, m0_ack}, 32'd0);
    checkOutput("m0_rdata_hold", m0_rdata, 32'hABCD1234);
    checkOutput("m0_ack_count", m0_ack_cnt, 32'd1);

    // Both request; m0 was served last so m1 (write) wins this tie
    @(posedge clk); #1;
    start_req(0, 1'b0, 22'h10, 32'h0);
    start_req(1, 1'b1, 22'h3, 32'hDEADBEEF);
    wait_both(lat0, lat1);
    checkOutput("rr_m1_latency", lat1, 32'd9);
    checkOutput("rr_m0_latency", lat0, 32'd19);
    checkOutput("wr_count", wr_count, 32'd2);
    checkOutput("wr0_addr", {9'd0, wr_addr_log[0]}, 32'h6);
    checkOutput("wr0_data", {16'd0, wr_data_log[0]}, 32'hBEEF);
    checkOutput("wr1_addr", {9'd0, wr_addr_log[1]}, 32'h7);
    checkOutput("wr1_data", {16'd0, wr_data_log[1]}, 32'hDEAD);
    checkOutput("m1_ack_count", m1_ack_cnt, 32'd1);
    checkOutput("m1_wr_rdata", m1_rdata, 32'd0);
    checkOutput("rr_m0_data", m0_rdata, 32'hABCD1234);

    // After reset the pointer is back on m0
    do_reset();
    @(negedge clk);
    checkOutput("rst2_m0_rdata", m0_rdata, 32'd0);
    @(posedge clk); #1;
    start_req(0, 1'b0, 22'h10, 32'h0);
    start_req(1, 1'b0, 22'h3, 32'h0);
    wait_both(lat0, lat1);
    checkOutput("both_m0_latency", lat0, 32'd9);
    checkOutput("both_m1_latency", lat1, 32'd19);
    checkOutput("both_m0_data", m0_rdata, 32'hABCD1234);
    checkOutput("both_m1_data", m1_rdata, 32'hDEADBEEF);

    // Reset while in REQ_HI (cycle 5) aborts without ack
    @(posedge clk); #1;
    start_req(0, 1'b0, 22'h10, 32'h0);
    repeat (6) @(negedge clk);
    checkOutput("mid_ce", {31'd0, flash_ce}, 32'd1);
    checkOutput("mid_addr", {9'd0, flash_addr}, 32'h21);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    acks_before = m0_ack_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_ce", {31'd0, flash_ce}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_m0_rdata", m0_rdata, 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort_no_ack", m0_ack_cnt, acks_before);
    @(posedge clk); #1;
    start_req(1, 1'b0, 22'h3, 32'h0);
    wait_ack(1, lat);
    checkOutput("post_abort_latency", lat, 32'd9);
    checkOutput("post_abort_data", m1_rdata, 32'hDEADBEEF);

    // Stale ready held high in IDLE blocks the grant until it drops
    @(posedge clk); #1;
    force_ready = 1'b1;
    start_req(0, 1'b0, 22'h3, 32'h0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("stuck_ce", {31'd0, flash_ce}, 32'd0);
      checkOutput("stuck_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    force_ready = 1'b0;
    wait_ack(0, lat);
    checkOutput("stuck_latency", lat, 32'd9);
    checkOutput("stuck_data", m0_rdata, 32'hDEADBEEF);
    checkOutput("final_err", {31'd0, err}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
